// File: rtl/bip_prog_loader.sv
// Serial program loader: takes a count-prefixed byte stream from a UART and
// writes it into program memory, holding the CPU in reset until loading completes.
module bip_prog_loader #(
    parameter int NB_BITS       = 16,
    parameter int INS_MEM_DEPTH = 2048,
    // Bits needed to address 0..INS_MEM_DEPTH-1 (11 at the default depth)
    localparam int NB_ADDR      = $clog2(INS_MEM_DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_reload,
    output logic               o_wr_en,
    output logic [NB_ADDR-1:0] o_wr_addr,
    output logic [NB_BITS-1:0] o_wr_data,
    output logic               o_cpu_rst,
    output logic               o_done,
    output logic               o_err
);

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        WRD_HI = 3'd2,
        WRD_LO = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          n_q, n_d;
    logic [7:0]           hi_q, hi_d;
    logic [NB_ADDR-1:0]   k_q, k_d;
    logic                 wr_en_q, wr_en_d;
    logic [NB_ADDR-1:0]   wr_addr_q, wr_addr_d;
    logic [NB_BITS-1:0]   wr_data_q, wr_data_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [15:0]          n_full;
    logic                 last_word;

    assign n_full    = {n_q[15:8], i_rx_data};
    assign last_word = (32'(k_q) == (32'(n_q) - 32'd1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= CNT_HI;
            n_q       <= '0;
            hi_q      <= '0;
            k_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            hi_q      <= hi_d;
            k_q       <= k_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        hi_d      = hi_q;
        k_d       = k_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cpu_rst_d = cpu_rst_q;
        done_d    = done_q;
        err_d     = err_q;

        case (state_q)
            CNT_HI: begin
                if (i_rx_valid) begin
                    n_d     = {i_rx_data, 8'h00};
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (i_rx_valid) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        // Empty program: release the CPU straight away
                        state_d   = RUN;
                        cpu_rst_d = 1'b0;
                        done_d    = 1'b1;
                    end else if (32'(n_full) > INS_MEM_DEPTH) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WRD_HI;
                        k_d     = '0;
                    end
                end
            end
            WRD_HI: begin
                if (i_rx_valid) begin
                    hi_d    = i_rx_data;
                    state_d = WRD_LO;
                end
            end
            WRD_LO: begin
                if (i_rx_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = k_q;
                    wr_data_d = NB_BITS'({hi_q, i_rx_data});
                    k_d       = k_q + NB_ADDR'(1);
                    // CPU reset drops one cycle later, from RUN, after the final pulse
                    state_d   = last_word ? RUN : WRD_HI;
                end
            end
            RUN: begin
                cpu_rst_d = 1'b0;
                done_d    = 1'b1;
                if (i_reload) begin
                    state_d   = CNT_HI;
                    cpu_rst_d = 1'b1;
                    done_d    = 1'b0;
                    k_d       = '0;
                end
            end
            ERR: begin
                err_d     = 1'b1;
                cpu_rst_d = 1'b1;
                done_d    = 1'b0;
            end
            default: state_d = CNT_HI;
        endcase
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;
    assign o_cpu_rst = cpu_rst_q;
    assign o_done    = done_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_bip_prog_loader.sv
// Directed bench for bip_prog_loader: byte streams in, observed write pulses
// collected into a queue and compared against hand-computed expectations.
module tb_bip_prog_loader;

    localparam int AW = 11;
    localparam int W  = AW + 16;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          reload;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          cpu_rst;
    logic          done;
    logic          err;

    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  got_q[$];
    int            checks = 0;
    int            errors = 0;

    bip_prog_loader dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .i_reload   (reload),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_cpu_rst  (cpu_rst),
        .o_done     (done),
        .o_err      (err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every cycle with the write strobe high is one observed write
    always @(negedge clk) begin
        if (wr_en) got_q.push_back({wr_addr, wr_data});
    end

    // Drivers: all called at posedge+1 and return at posedge+1
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF; reload = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0; reload = 1'b0;
        checks++;
        if ({cpu_rst, wr_en, wr_addr, wr_data, done, err} !== {1'b1, 1'b0, 11'd0, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rst=%b en=%b addr=%0d data=%h done=%b err=%b exp 1 0 0 0000 0 0",
                     cpu_rst, wr_en, wr_addr, wr_data, done, err);
        end
        got_q.delete();
    endtask

    task automatic test_two_words();
        do_reset();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 11'd0, 16'h1234}) begin
            errors++;
            $display("FAIL two_words_first_pulse got en=%b addr=%0d data=%h exp 1 0 1234", wr_en, wr_addr, wr_data);
        end
        send_byte(8'hAB); send_byte(8'hCD);
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 11'd1, 16'hABCD}) begin
            errors++;
            $display("FAIL two_words_second_pulse got en=%b addr=%0d data=%h exp 1 1 abcd", wr_en, wr_addr, wr_data);
        end
        checks++;
        if ({cpu_rst, done} !== 2'b10) begin
            errors++;
            $display("FAIL two_words_still_loading got cpu_rst=%b done=%b exp 1 0", cpu_rst, done);
        end
        idle(1);
        checks++;
        if ({cpu_rst, done} !== 2'b01) begin
            errors++;
            $display("FAIL two_words_run got cpu_rst=%b done=%b exp 0 1", cpu_rst, done);
        end
        checks++;
        if ({wr_en, wr_addr, wr_data} !== {1'b0, 11'd1, 16'hABCD}) begin
            errors++;
            $display("FAIL two_words_hold got en=%b addr=%0d data=%h exp 0 1 abcd", wr_en, wr_addr, wr_data);
        end
        idle(2);
        exp_q.push_back({11'd0, 16'h1234});
        exp_q.push_back({11'd1, 16'hABCD});
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL two_words_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL two_words_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        send_byte(8'h00); send_byte(8'h00);
        checks++;
        if ({cpu_rst, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL zero_count_run got cpu_rst=%b done=%b err=%b exp 0 1 0", cpu_rst, done, err);
        end
        // Bytes in RUN must be ignored
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        idle(2);
        checks++;
        if (got_q.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_count_ignore got writes=%0d done=%b exp 0 1", got_q.size(), done);
        end
    endtask

    task automatic test_err();
        do_reset();
        send_byte(8'h08); send_byte(8'h01);
        checks++;
        if ({cpu_rst, done, err} !== 3'b101) begin
            errors++;
            $display("FAIL err_enter got cpu_rst=%b done=%b err=%b exp 1 0 1", cpu_rst, done, err);
        end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        reload = 1'b1; idle(1); reload = 1'b0;
        idle(2);
        checks++;
        if ({cpu_rst, done, err} !== 3'b101 || got_q.size() != 0) begin
            errors++;
            $display("FAIL err_sticky got cpu_rst=%b done=%b err=%b writes=%0d exp 1 0 1 0",
                     cpu_rst, done, err, got_q.size());
        end
    endtask

    task automatic test_max_depth();
        logic [15:0] w;
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL max_err_cleared got %b exp 0", err);
        end
        send_byte(8'h08); send_byte(8'h00);
        for (int i = 0; i < 2048; i++) begin
            w = {8'(i) ^ 8'h5A, ~8'(i)};
            exp_q.push_back({11'(i), w});
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        idle(2);
        checks++;
        if ({cpu_rst, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL max_run got cpu_rst=%b done=%b err=%b exp 0 1 0", cpu_rst, done, err);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL max_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL max_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reload();
        do_reset();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h0F); send_byte(8'h0F);
        idle(1);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reload_first_run got done=%b exp 1", done);
        end
        // Reload and a byte together: the byte is dropped
        rx_data = 8'h77; rx_valid = 1'b1; reload = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0; reload = 1'b0;
        checks++;
        if ({cpu_rst, done} !== 2'b10) begin
            errors++;
            $display("FAIL reload_reassert got cpu_rst=%b done=%b exp 1 0", cpu_rst, done);
        end
        send_byte(8'h00); send_byte(8'h01);
        reload = 1'b1; idle(1); reload = 1'b0;
        send_byte(8'h11); send_byte(8'h11);
        idle(2);
        checks++;
        if ({cpu_rst, done, err} !== 3'b010) begin
            errors++;
            $display("FAIL reload_second_run got cpu_rst=%b done=%b err=%b exp 0 1 0", cpu_rst, done, err);
        end
        exp_q.push_back({11'd0, 16'h0F0F});
        exp_q.push_back({11'd0, 16'h1111});
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reload_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reload_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Starts in RUN with write data 0x1111 left from the previous load
        reload = 1'b1; idle(1); reload = 1'b0;
        got_q.delete();
        exp_q.delete();
        send_byte(8'h00); send_byte(8'h03); send_byte(8'h55);
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h99; reload = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0; reload = 1'b0;
        checks++;
        if ({cpu_rst, wr_en, wr_addr, wr_data, done, err} !== {1'b1, 1'b0, 11'd0, 16'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_values got rst=%b en=%b addr=%0d data=%h done=%b err=%b exp 1 0 0 0000 0 0",
                     cpu_rst, wr_en, wr_addr, wr_data, done, err);
        end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'h55);
        idle(2);
        exp_q.push_back({11'd0, 16'hAA55});
        checks++;
        if (got_q.size() != 1 || done !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_reload got writes=%0d done=%b exp 1 1", got_q.size(), done);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_mid_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] stream [8];
        stream = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_byte(stream[i]);
            idle($urandom_range(0, 20));
        end
        idle(2);
        exp_q.push_back({11'd0, 16'hDEAD});
        exp_q.push_back({11'd1, 16'hBEEF});
        exp_q.push_back({11'd2, 16'h0102});
        checks++;
        if ({cpu_rst, done} !== 2'b01) begin
            errors++;
            $display("FAIL gaps_run got cpu_rst=%b done=%b exp 0 1", cpu_rst, done);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gaps_count got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_write[%0d] got %h exp %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_two_words();
        test_zero_count();
        test_err();
        test_max_depth();
        test_reload();
        test_reset_mid();
        test_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bip_prog_loader.md
BIP_PROG_LOADER -- requirements
Module: bip_prog_loader

Interface
REQ-001 SHALL have parameter NB_BITS, default 16, instruction word width (fixed at two bytes).
REQ-002 SHALL have parameter INS_MEM_DEPTH, default 2048, program memory depth in words.
REQ-003 SHALL have localparam NB_ADDR = clogb2(INS_MEM_DEPTH-1), 11 at default.
REQ-004 SHALL have port i_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_rx_data  input  8  received UART byte.
REQ-007 SHALL have port i_rx_valid  input  1  one-cycle strobe; i_rx_data valid this cycle.
REQ-008 SHALL have port i_reload  input  1  one-cycle request to load a new program.
REQ-009 SHALL have port o_wr_en  output  1  program memory write strobe.
REQ-010 SHALL have port o_wr_addr  output  NB_ADDR  program memory write address.
REQ-011 SHALL have port o_wr_data  output  NB_BITS  program memory write data.
REQ-012 SHALL have port o_cpu_rst  output  1  active-high reset to the CPU; held while loading.
REQ-013 SHALL have port o_done  output  1  high while the loaded program runs.
REQ-014 SHALL have port o_err  output  1  sticky: illegal word count received.

Function
REQ-015 SHALL implement FSM states CNT_HI, CNT_LO, WRD_HI, WRD_LO, RUN, ERR; all outputs registered.
REQ-016 SHALL treat the stream as: count N (16 bit, high byte first), then N words, each high byte first.
REQ-017 SHALL accept exactly one byte per cycle in which i_rx_valid=1; no other cycle advances the FSM.
REQ-018 SHALL, in CNT_HI on a valid byte, store N[15:8] and go to CNT_LO.
REQ-019 SHALL, in CNT_LO on a valid byte: N=0 -> RUN; N>INS_MEM_DEPTH -> ERR; otherwise -> WRD_HI with word index k=0.
REQ-020 SHALL, in WRD_HI on a valid byte, store word[15:8] and go to WRD_LO.
REQ-021 SHALL, in WRD_LO on a valid byte at edge E, drive o_wr_en=1, o_wr_addr=k, o_wr_data={hi,lo} for exactly the cycle after E.
REQ-022 SHALL increment k after each write; if k was N-1, go to RUN, else WRD_HI.
REQ-023 SHALL, on entering RUN, drive o_cpu_rst=0 and o_done=1 starting the cycle after the last write pulse (one cycle after E for N=0).
REQ-024 SHALL ignore i_rx_valid in RUN and ERR; no write strobes are issued there.
REQ-025 SHALL, on i_reload=1 in RUN, go to CNT_HI with o_cpu_rst=1, o_done=0, k=0 from the next cycle.
REQ-026 SHALL ignore i_reload in every state other than RUN.
REQ-027 SHALL give i_reload priority over i_rx_valid when both are high in RUN; the byte is dropped.
REQ-028 SHALL, in ERR, hold o_err=1 and o_cpu_rst=1 and o_done=0 until i_rst.
REQ-029 SHALL never let o_wr_addr exceed INS_MEM_DEPTH-1; N=INS_MEM_DEPTH is legal and fills addresses 0..INS_MEM_DEPTH-1.
REQ-030 SHALL hold o_wr_addr and o_wr_data stable when o_wr_en=0.

Reset
REQ-031 SHALL, with i_rst=1 at a clock edge, enter CNT_HI with o_cpu_rst=1, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_err=0, k=0.
REQ-032 SHALL abort any partial load on reset mid-operation; the next byte after reset is treated as count high byte.
REQ-033 SHALL give i_rst priority over i_rx_valid and i_reload in the same cycle.

Verification
REQ-034 SHALL pass: bytes 00 02 12 34 AB CD -> writes (0,0x1234), (1,0xABCD) one cycle after each low byte; o_cpu_rst falls, o_done rises one cycle after second write.
REQ-035 SHALL pass: bytes 00 00 -> no o_wr_en; o_cpu_rst=0 and o_done=1 one cycle after second byte.
REQ-036 SHALL pass: bytes 08 01 (N=2049) -> o_err=1, no writes, o_cpu_rst stays 1; further bytes ignored until i_rst.
REQ-037 SHALL pass: load N=1 word 0x0F0F, pulse i_reload in RUN, load N=1 word 0x1111 -> o_cpu_rst reasserted next cycle; second write at address 0 with 0x1111.
REQ-038 SHALL pass: i_rst after bytes 00 03 55 -> outputs return to reset values; then 00 01 AA 55 -> single write (0,0xAA55).
REQ-039 SHALL pass: bytes with idle gaps of 0..20 cycles between i_rx_valid strobes -> identical writes and addresses as back-to-back delivery.
